// File: rtl/i2s_pkg.sv
// Shared I2S constants and helpers for the transmit and receive paths.
package i2s_pkg;

  localparam int unsigned DEF_NUMBER_OF_BITS = 8;
  localparam int unsigned DEF_SLOT_BITS      = 32;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // Counter/index width for a range of n positions (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// Slot counter and word-select generator; exposes next-cycle bit position
// so the serialiser can register sd in step with ws.
module i2s_frame_timer
  import i2s_pkg::*;
#(
  parameter int unsigned NUMBER_OF_BITS = DEF_NUMBER_OF_BITS,
  parameter int unsigned SLOT_BITS      = DEF_SLOT_BITS
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic                                   ws_o,
  output logic                                   ws_next_c,
  output logic                                   frame_boundary_c,
  output logic                                   bit_active_c,
  output logic [cnt_width(NUMBER_OF_BITS)-1:0]   bit_idx_c
);

  localparam int unsigned CNT_W = cnt_width(SLOT_BITS);
  localparam int unsigned IDX_W = cnt_width(NUMBER_OF_BITS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ws_q, ws_d;
  logic             wrap_c;

  always_comb begin
    wrap_c = (cnt_q == CNT_W'(SLOT_BITS - 1));
    cnt_d  = cnt_q + CNT_W'(1);
    ws_d   = ws_q;
    if (wrap_c) begin
      cnt_d = '0;
      ws_d  = ~ws_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ws_q  <= WS_LEFT;
    end else begin
      cnt_q <= cnt_d;
      ws_q  <= ws_d;
    end
  end

  assign ws_o             = ws_q;
  assign ws_next_c        = ws_d;
  assign frame_boundary_c = wrap_c && (ws_q == WS_RIGHT);
  // Data bits occupy cnt = 1..NUMBER_OF_BITS, MSB first, after the one-bit I2S delay.
  assign bit_active_c     = (cnt_d != '0) && (32'(cnt_d) <= NUMBER_OF_BITS);
  assign bit_idx_c        = IDX_W'(NUMBER_OF_BITS - 32'(cnt_d));

endmodule

// File: rtl/i2s_pcm_transmitter.sv
// Parallel stereo PCM to I2S serialiser with a one-deep holding register
// feeding the per-frame word registers, plus underrun reporting.
module i2s_pcm_transmitter
  import i2s_pkg::*;
#(
  parameter int unsigned NUMBER_OF_BITS = DEF_NUMBER_OF_BITS,
  parameter int unsigned SLOT_BITS      = DEF_SLOT_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUMBER_OF_BITS-1:0] in_left,
  input  logic [NUMBER_OF_BITS-1:0] in_right,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      ws,
  output logic                      sd,
  output logic                      underrun
);

  localparam int unsigned IDX_W = cnt_width(NUMBER_OF_BITS);

  typedef logic [NUMBER_OF_BITS-1:0] word_t;

  word_t            hold_left_q, hold_left_d, hold_right_q, hold_right_d;
  word_t            sh_left_q, sh_left_d, sh_right_q, sh_right_d;
  word_t            word_c;
  logic             in_ready_q, in_ready_d;
  logic             underrun_q, underrun_d;
  logic             sd_q, sd_d;
  logic             hs_c;
  logic             ws_next_c, frame_boundary_c, bit_active_c;
  logic [IDX_W-1:0] bit_idx_c;

  i2s_frame_timer #(
    .NUMBER_OF_BITS (NUMBER_OF_BITS),
    .SLOT_BITS      (SLOT_BITS)
  ) u_frame_timer (
    .clk              (clk),
    .reset            (reset),
    .ws_o             (ws),
    .ws_next_c        (ws_next_c),
    .frame_boundary_c (frame_boundary_c),
    .bit_active_c     (bit_active_c),
    .bit_idx_c        (bit_idx_c)
  );

  // in_ready doubles as the holding-register-empty flag.
  always_comb begin
    hs_c         = in_valid && in_ready_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    sh_left_d    = sh_left_q;
    sh_right_d   = sh_right_q;
    in_ready_d   = in_ready_q;
    underrun_d   = 1'b0;

    if (frame_boundary_c) begin
      if (!in_ready_q) begin
        sh_left_d  = hold_left_q;
        sh_right_d = hold_right_q;
        in_ready_d = 1'b1;
      end else if (hs_c) begin
        sh_left_d  = in_left;
        sh_right_d = in_right;
      end else begin
        sh_left_d  = '0;
        sh_right_d = '0;
        underrun_d = 1'b1;
      end
    end else if (hs_c) begin
      hold_left_d  = in_left;
      hold_right_d = in_right;
      in_ready_d   = 1'b0;
    end

    word_c = (ws_next_c == WS_RIGHT) ? sh_right_d : sh_left_d;
    sd_d   = bit_active_c ? word_c[bit_idx_c] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_left_q  <= '0;
      hold_right_q <= '0;
      sh_left_q    <= '0;
      sh_right_q   <= '0;
      in_ready_q   <= 1'b1;
      underrun_q   <= 1'b0;
      sd_q         <= 1'b0;
    end else begin
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      sh_left_q    <= sh_left_d;
      sh_right_q   <= sh_right_d;
      in_ready_q   <= in_ready_d;
      underrun_q   <= underrun_d;
      sd_q         <= sd_d;
    end
  end

  assign in_ready = in_ready_q;
  assign underrun = underrun_q;
  assign sd       = sd_q;

endmodule
